sevenseg_decoder: RTL and testbench

Sequential decoder for the DE1-SoC seven-segment code: the reverse of the BCD-to-segment encoder used by the memory game. It samples a 7-bit active-low segment pattern and waits until the pattern is stable for a set number of samples. It then decodes the pattern back to a 0–9 digit, flags blank or illegal codes, and shifts each accepted digit into a history register. The game logic uses this history to compare a played-back display sequence against the stored sequence.

---
 rtl/sevenseg_decoder.sv | 163 ++++++++++++++++
 tb/tb_sevenseg_decoder.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_decoder.sv
//------------------------------------------------------------------------------
// Module   : sevenseg_decoder
// Purpose  : Debounces an active-low seven-segment pattern (gfe_dcba), decodes
//            it back to a 0-9 digit, flags blank/illegal codes and shifts each
//            accepted digit into a newest-at-[3:0] history register.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sevenseg_decoder #(
  parameter int STABLE_CYCLES = 4,  // 1..15
  parameter int DEPTH         = 4   // 1..7
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 sample_en,
  input  logic                 clear,
  input  logic [6:0]           ledsegments,
  output logic [3:0]           digit,
  output logic                 digit_valid,
  output logic                 blank,
  output logic                 code_error,
  output logic [4*DEPTH-1:0]   history,
  output logic [2:0]           count
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;

  localparam logic [3:0] C_STABLE  = 4'(STABLE_CYCLES);
  localparam logic [2:0] C_DEPTH   = 3'(DEPTH);
  localparam logic [6:0] C_BLANK   = 7'b111_1111;

  logic [1:0]         r_state;
  logic [6:0]         r_cand;
  logic [3:0]         r_stab;
  logic [3:0]         r_digit;
  logic               r_digit_valid;
  logic               r_blank;
  logic               r_code_error;
  logic [4*DEPTH-1:0] r_history;
  logic [2:0]         r_count;

  logic               w_match;
  logic               w_load;
  logic               w_update;
  logic [3:0]         w_stab_next;
  logic               w_accept;
  logic [3:0]         w_dec_digit;
  logic               w_is_digit;
  logic               w_is_blank;
  logic [4*DEPTH-1:0] w_hist_shift;

  // Stability tracking: a new candidate starts a run of 1, a repeat extends it
  // (saturating), and the run reaching STABLE_CYCLES is the accept condition.
  always_comb begin
    w_match     = (ledsegments == r_cand);
    w_load      = (r_state == S_IDLE) || !w_match;
    // A matching sample while locked is ignored entirely (no re-emission).
    w_update    = sample_en && !((r_state == S_LOCKED) && w_match);
    if (w_load) begin
      w_stab_next = 4'd1;
    end else if (r_stab == C_STABLE) begin
      w_stab_next = r_stab;
    end else begin
      w_stab_next = r_stab + 4'd1;
    end
    w_accept    = w_update && !clear && (w_stab_next == C_STABLE);
  end

  // Reverse of the BCD-to-segment table; anything not listed is illegal.
  always_comb begin
    w_dec_digit = 4'd0;
    w_is_digit  = 1'b1;
    w_is_blank  = 1'b0;
    case (ledsegments)
      7'b100_0000: w_dec_digit = 4'd0;
      7'b111_1001: w_dec_digit = 4'd1;
      7'b010_0100: w_dec_digit = 4'd2;
      7'b011_0000: w_dec_digit = 4'd3;
      7'b001_1001: w_dec_digit = 4'd4;
      7'b001_0010: w_dec_digit = 4'd5;
      7'b000_0010: w_dec_digit = 4'd6;
      7'b111_1000: w_dec_digit = 4'd7;
      7'b000_0000: w_dec_digit = 4'd8;
      7'b001_0000: w_dec_digit = 4'd9;
      C_BLANK: begin
        w_is_digit = 1'b0;
        w_is_blank = 1'b1;
      end
      default: w_is_digit = 1'b0;
    endcase
  end

  // The history shift needs a lower slice only when more than one digit is kept.
  generate
    if (DEPTH == 1) begin : g_hist_single
      assign w_hist_shift = w_dec_digit;
    end else begin : g_hist_multi
      assign w_hist_shift = {r_history[4*DEPTH-5:0], w_dec_digit};
    end
  endgenerate

  // FSM, candidate/stability registers and registered accept outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_cand        <= C_BLANK;
      r_stab        <= 4'd0;
      r_digit       <= 4'd0;
      r_digit_valid <= 1'b0;
      r_blank       <= 1'b0;
      r_code_error  <= 1'b0;
      r_history     <= '0;
      r_count       <= 3'd0;
    end else if (clear) begin
      r_state       <= S_IDLE;
      r_cand        <= C_BLANK;
      r_stab        <= 4'd0;
      r_digit       <= 4'd0;
      r_digit_valid <= 1'b0;
      r_blank       <= 1'b0;
      r_code_error  <= 1'b0;
      r_history     <= '0;
      r_count       <= 3'd0;
    end else begin
      r_digit_valid <= 1'b0;
      r_code_error  <= 1'b0;
      if (w_update) begin
        r_cand  <= ledsegments;
        r_stab  <= w_stab_next;
        r_state <= w_accept ? S_LOCKED : S_SETTLE;
      end
      if (w_accept) begin
        if (w_is_digit) begin
          r_digit       <= w_dec_digit;
          r_digit_valid <= 1'b1;
          r_blank       <= 1'b0;
          r_history     <= w_hist_shift;
          if (r_count != C_DEPTH) begin
            r_count <= r_count + 3'd1;
          end
        end else if (w_is_blank) begin
          r_blank <= 1'b1;
        end else begin
          r_code_error <= 1'b1;
          r_blank      <= 1'b0;
        end
      end
    end
  end

  assign digit       = r_digit;
  assign digit_valid = r_digit_valid;
  assign blank       = r_blank;
  assign code_error  = r_code_error;
  assign history     = r_history;
  assign count       = r_count;

endmodule

`default_nettype wire

// File: tb/tb_sevenseg_decoder.sv
//------------------------------------------------------------------------------
// Module   : tb_sevenseg_decoder
// Purpose  : Scoreboard bench for sevenseg_decoder; a run-length reference
//            model predicts accepts, a monitor checks every output pulse.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sevenseg_decoder;

  localparam int SC = 4;
  localparam int DP = 4;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            sample_en;
  logic            clear;
  logic [6:0]      led;
  logic [3:0]      digit;
  logic            digit_valid;
  logic            blank;
  logic            code_error;
  logic [4*DP-1:0] history;
  logic [2:0]      count;

  sevenseg_decoder #(.STABLE_CYCLES(SC), .DEPTH(DP)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sample_en   (sample_en),
    .clear       (clear),
    .ledsegments (led),
    .digit       (digit),
    .digit_valid (digit_valid),
    .blank       (blank),
    .code_error  (code_error),
    .history     (history),
    .count       (count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Segment code of each digit, active-low gfe_dcba.
  logic [6:0] seg [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                           7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  // 0..9 for a digit, 10 for blank, -1 for illegal.
  function automatic int seg_to_digit(input logic [6:0] p);
    if (p == 7'h7F) return 10;
    for (int i = 0; i < 10; i++) if (seg[i] == p) return i;
    return -1;
  endfunction

  // Reference model: an accept happens exactly when the run of identical
  // enabled samples since the last reset/clear reaches length SC.
  logic [6:0] m_run_val;
  int         m_run_len;
  int         m_hist[$];   // newest at index 0
  int         m_count;
  int         m_digit;
  bit         m_blank;

  typedef struct { int cyc; bit is_err; int dig; } exp_t;
  exp_t sbq[$];

  task automatic model_reset();
    m_run_len = 0;
    m_hist.delete();
    m_count = 0;
    m_digit = 0;
    m_blank = 0;
  endtask

  function automatic logic [4*DP-1:0] exp_hist();
    logic [4*DP-1:0] v = '0;
    for (int i = 0; i < m_hist.size(); i++) v[4*i +: 4] = 4'(m_hist[i]);
    return v;
  endfunction

  task automatic model_step(input bit en, input bit clr, input logic [6:0] p);
    int d;
    exp_t e;
    if (clr) begin
      model_reset();
      return;
    end
    if (!en) return;
    if (m_run_len > 0 && p == m_run_val) m_run_len++;
    else begin
      m_run_val = p;
      m_run_len = 1;
    end
    if (m_run_len == SC) begin
      d = seg_to_digit(p);
      if (d >= 0 && d <= 9) begin
        m_digit = d;
        m_blank = 0;
        m_hist.push_front(d);
        if (m_hist.size() > DP) void'(m_hist.pop_back());
        if (m_count < DP) m_count++;
        e.cyc = cyc + 1; e.is_err = 0; e.dig = d;
        sbq.push_back(e);
      end else if (d == 10) begin
        m_blank = 1;
      end else begin
        m_blank = 0;
        e.cyc = cyc + 1; e.is_err = 1; e.dig = 0;
        sbq.push_back(e);
      end
    end
  endtask

  // Monitor: every cycle either the expected pulse or no pulse at all.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n === 1'b1) begin
      if (digit_valid && code_error)
        chk("pulse_exclusive", {digit_valid, code_error}, 2'b00);
      if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
        e = sbq.pop_front();
        chk("pulse_valid", digit_valid, !e.is_err);
        chk("pulse_error", code_error, e.is_err);
        if (!e.is_err) chk("pulse_digit", digit, e.dig);
      end else begin
        chk("no_pulse", {digit_valid, code_error}, 2'b00);
      end
    end
  end

  // One sample slot: check levels from the previous edge, then drive.
  task automatic drive(input bit en, input bit clr, input logic [6:0] p);
    @(negedge clk);
    #1;
    chk("digit", digit, m_digit);
    chk("blank", blank, m_blank);
    chk("count", count, m_count);
    chk("history", history, exp_hist());
    sample_en = en;
    clear     = clr;
    led       = p;
    model_step(en, clr, p);
  endtask

  task automatic hold(input logic [6:0] p, input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, p);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, led);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_digit", digit, 0);
    chk("rst_valid", digit_valid, 0);
    chk("rst_blank", blank, 0);
    chk("rst_error", code_error, 0);
    chk("rst_history", history, 0);
    chk("rst_count", count, 0);
    sbq.delete();
    model_reset();
    sample_en = 1'b0;
    clear     = 1'b0;
    @(posedge clk);
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    int kind, len, d;
    bit en, clr;
    logic [6:0] p;

    reset_n   = 1'b0;
    sample_en = 1'b0;
    clear     = 1'b0;
    led       = 7'h7F;
    model_reset();
    #1;
    chk("reset_digit", digit, 0);
    chk("reset_history", history, 0);
    chk("reset_count", count, 0);
    chk("reset_blank", blank, 0);
    @(posedge clk);
    #2;
    reset_n = 1'b1;

    // Settle and accept, then a long hold with no re-emission.
    hold(seg[2], 4);
    idle();
    chk("tp_accept_digit", digit, 2);
    chk("tp_accept_count", count, 1);
    chk("tp_accept_hist", history[3:0], 2);
    hold(seg[2], 10);

    // Glitch rejection from a fresh start.
    drive(1'b1, 1'b1, seg[2]);
    hold(seg[2], 3);
    hold(seg[1], 1);
    hold(seg[2], 3);
    idle();
    chk("tp_glitch_none", count, 0);
    hold(seg[2], 1);
    idle();
    chk("tp_glitch_count", count, 1);

    // Repeat of a digit via blank.
    drive(1'b0, 1'b1, 7'h7F);
    hold(seg[5], 4);
    hold(7'h7F, 4);
    idle();
    chk("tp_blank_level", blank, 1);
    hold(seg[5], 4);
    idle();
    chk("tp_repeat_hist", history[7:0], 8'h55);

    // Illegal code leaves the digit state untouched.
    hold(7'h55, 4);
    idle();
    chk("tp_illegal_count", count, 2);
    chk("tp_illegal_digit", digit, 5);

    // History wrap with saturating count.
    drive(1'b0, 1'b1, 7'h7F);
    for (int i = 1; i <= 5; i++) begin
      hold(seg[i], 4);
      hold(7'h7F, 4);
    end
    idle();
    chk("tp_wrap_hist", history, 16'h2345);
    chk("tp_wrap_count", count, 4);

    // Clear on the accepting edge discards the accept.
    hold(seg[7], 3);
    drive(1'b1, 1'b1, seg[7]);
    idle();
    chk("tp_clear_count", count, 0);
    chk("tp_clear_hist", history, 0);
    hold(seg[7], 3);
    idle();
    chk("tp_clear_idle", count, 0);
    hold(seg[7], 1);

    // Reset mid-settle, then a fresh settle.
    hold(seg[3], 2);
    pulse_reset();
    hold(seg[3], 3);
    idle();
    chk("tp_rst_settle", count, 0);
    hold(seg[3], 1);
    idle();
    chk("tp_rst_accept", digit, 3);

    // Randomised bursts of patterns with gaps in sample_en and rare clears.
    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 5) begin
        p = seg[$urandom_range(0, 9)];
      end else if (kind <= 7) begin
        p = 7'h7F;
      end else begin
        do begin
          p = 7'($urandom);
          d = seg_to_digit(p);
        end while (d != -1);
      end
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++) begin
        en  = ($urandom_range(0, 9) != 0);
        clr = ($urandom_range(0, 99) == 0);
        drive(en, clr, p);
      end
    end

    idle();
    idle();
    idle();
    chk("scoreboard_drain", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
